usr_burst: RTL and testbench
============================

// Module: usr_burst
// PURPOSE
//  Parametrised universal shift register with a multi-step command engine.
//  A valid/ready command loads, clears, or shifts/rotates the register by a programmed count of W-bit lanes.
//  One lane moves per clock. Serial lanes enter via lin/rin and leave via sout_l/sout_r.
//  Used as the serialiser/deserialiser and bit-manipulation core in the datapath.
// PARAMETERS
//  N   8                  register width in bits; N % W == 0, N/W >= 2
//  W   1                  lane width (bits moved per step)
//  CW  $clog2(N/W)+1      step-count width; counts 0..2**CW-1 legal
// PORTS
//  clk        in   1   single clock, rising edge
//  n_reset    in   1   asynchronous, active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   engine can accept (high only in IDLE)
//  cmd_op     in   3   usr_pkg::op_t
//  cmd_count  in   CW  number of lane steps for shift/rotate ops
//  cmd_data   in   N   load value (OP_LOAD only)
//  lin        in   W   lane entering at LSB end on OP_SHL, sampled each step
//  rin        in   W   lane entering at MSB end on OP_SHR, sampled each step
//  q          out  N   register contents
//  sout_l     out  W   lane most recently shifted/rotated out of MSB end
//  sout_r     out  W   lane most recently shifted/rotated out of LSB end
//  busy       out  1   multi-step operation in progress (== !cmd_ready)
//  done       out  1   one-cycle pulse: command completed
// BEHAVIOUR
//  Reset (async, any state): q=0, sout_l=sout_r=0, state=IDLE, count=0, done=0, busy=0, cmd_ready=1.
//  Accept = cmd_valid & cmd_ready. The source holds op/count/data stable while valid & !ready.
//  Ops:
//   HOLD=0:  no change.
//   LOAD=1:  q<=cmd_data.
//   SHL=2:   q<={q[N-W-1:0],lin}, sout_l<=q[N-1:N-W].
//   SHR=3:   q<={rin,q[N-1:W]}, sout_r<=q[W-1:0].
//   ROL=4:   as SHL, fill = old MSB lane.
//   ROR=5:   as SHR, fill = old LSB lane.
//   ASR=6:   as SHR, fill = {W{q[N-1]}}.
//   CLR=7:   q<=0.
//  Only the out-lane relevant to the op updates on a step; the other holds.
//  FSM IDLE/SHIFT:
//   IDLE + accept of HOLD/LOAD/CLR, or a shift/rotate with cmd_count==0:
//    - op applied at the accept edge; stay IDLE.
//    - done=1 in the next cycle.
//   IDLE + accept of shift/rotate with cmd_count=k>0:
//    - the first step is applied at the accept edge; rem<=k-1; go SHIFT if k>1, else stay IDLE.
//   SHIFT: one step per edge, rem decrements. The step taken with rem==1 returns to IDLE.
//   Timing: k steps complete on k consecutive edges starting at accept. done=1 for exactly one cycle after the last step edge.
//  done and cmd_ready may both be high in the same cycle; back-to-back commands lose no cycles.
//  Command presented while busy: ignored (ready=0), no side effects.
//  Counts > N/W are legal:
//   - logical shifts fully flush the register with fill lanes;
//   - rotates wrap (k mod N/W net effect);
//   - ASR saturates to all sign bits.
//  lin/rin are sampled on every step edge, so the source streams one lane per cycle.
//  Reset mid-operation aborts the op; no done pulse is issued.
// STRUCTURE
//  usr_pkg:
//   - typedef enum logic [2:0] op_t {OP_HOLD, OP_LOAD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR, OP_CLR};
//   - typedef enum logic {S_IDLE, S_SHIFT} state_t.
//  Sub-module usr_step #(N,W): combinational single-step next-q and out-lane for a given op.
//  Instantiated once in usr_burst; the FSM latches op_t at accept and drives usr_step each step.
// TESTING
//  T1 reset: assert n_reset=0 mid-SHIFT (k=5) -> q=0, busy=0, ready=1 immediately (async), no done.
//  T2 N=8,W=1: LOAD 8'hA5 then SHL k=3, lin=1,0,1 -> q=8'h2D after 3 edges; sout_l=1; done 1 cycle; busy high 2 cycles.
//  T3 N=8,W=1: LOAD 8'h96, ASR k=2 -> q=8'hE5; then ROR k=9 from 8'h81 -> q=8'hC0, sout_r=1.
//  T4 N=8,W=2: LOAD 8'h1B, ROL k=4 -> q=8'h1B (full wrap); SHR k=1, rin=2'b11 -> q=8'hC6, sout_r=2'b11.
//  T5 handshake: cmd_valid held during SHIFT with a changing-free LOAD -> accepted only in the done cycle; zero-gap back-to-back; count=0 SHL -> q unchanged, done next cycle.
//  T6 random ops/counts/lanes vs reference model over 10k commands, incl. reset pulses; q/sout/done compared cycle-exact.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: command opcodes, engine states
// and the helper that tells stepping ops apart from single-cycle ops.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_SHL,
        OP_SHR,
        OP_ROL,
        OP_ROR,
        OP_ASR,
        OP_CLR
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // Shift/rotate ops consume cmd_count lane steps; the rest complete at once.
    function automatic logic is_step_op(input op_t op);
        return (op != OP_HOLD) && (op != OP_LOAD) && (op != OP_CLR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step datapath: next register value and the lanes at
// either end for one op, plus flags saying which out-lane the op updates.
module usr_step
    import usr_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] q,
    input  logic [N-1:0] data,
    input  logic [W-1:0] lin,
    input  logic [W-1:0] rin,
    output logic [N-1:0] q_next,
    output logic [W-1:0] lane_l,
    output logic [W-1:0] lane_r,
    output logic         upd_l,
    output logic         upd_r
);

    assign lane_l = q[N-1 -: W];
    assign lane_r = q[W-1:0];

    always_comb begin
        q_next = q;
        upd_l  = 1'b0;
        upd_r  = 1'b0;
        case (op_t'(op))
            OP_LOAD: q_next = data;
            OP_SHL: begin
                q_next = {q[N-W-1:0], lin};
                upd_l  = 1'b1;
            end
            OP_ROL: begin
                q_next = {q[N-W-1:0], lane_l};
                upd_l  = 1'b1;
            end
            OP_SHR: begin
                q_next = {rin, q[N-1:W]};
                upd_r  = 1'b1;
            end
            OP_ROR: begin
                q_next = {lane_r, q[N-1:W]};
                upd_r  = 1'b1;
            end
            OP_ASR: begin
                q_next = {{W{q[N-1]}}, q[N-1:W]};
                upd_r  = 1'b1;
            end
            OP_CLR: q_next = '0;
            default: ;
        endcase
    end

endmodule

// File: rtl/usr_burst.sv
// Universal shift register with a valid/ready command engine that applies
// shift/rotate ops one lane per clock for a programmed number of steps.
module usr_burst
    import usr_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int CW = $clog2(N / W) + 1
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [CW-1:0] cmd_count,
    input  logic [N-1:0]  cmd_data,
    input  logic [W-1:0]  lin,
    input  logic [W-1:0]  rin,
    output logic [N-1:0]  q,
    output logic [W-1:0]  sout_l,
    output logic [W-1:0]  sout_r,
    output logic          busy,
    output logic          done
);

    state_t        state_reg, state_next;
    op_t           op_reg, op_next;
    logic [CW-1:0] rem_reg, rem_next;
    logic [N-1:0]  q_reg, q_next;
    logic [W-1:0]  sout_l_reg, sout_l_next;
    logic [W-1:0]  sout_r_reg, sout_r_next;
    logic          done_reg, done_next;

    logic          apply;
    logic [2:0]    step_op;
    logic [N-1:0]  step_q;
    logic [W-1:0]  lane_l, lane_r;
    logic          upd_l, upd_r;

    // In IDLE the step unit sees the incoming command so the first step lands on the accept edge.
    assign step_op = (state_reg == S_IDLE) ? cmd_op : op_reg;

    usr_step #(
        .N(N),
        .W(W)
    ) u_step (
        .op    (step_op),
        .q     (q_reg),
        .data  (cmd_data),
        .lin   (lin),
        .rin   (rin),
        .q_next(step_q),
        .lane_l(lane_l),
        .lane_r(lane_r),
        .upd_l (upd_l),
        .upd_r (upd_r)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg  <= S_IDLE;
            op_reg     <= OP_HOLD;
            rem_reg    <= '0;
            q_reg      <= '0;
            sout_l_reg <= '0;
            sout_r_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            rem_reg    <= rem_next;
            q_reg      <= q_next;
            sout_l_reg <= sout_l_next;
            sout_r_reg <= sout_r_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        rem_next    = rem_reg;
        q_next      = q_reg;
        sout_l_next = sout_l_reg;
        sout_r_next = sout_r_reg;
        done_next   = 1'b0;
        apply       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_next = op_t'(cmd_op);
                    if (!is_step_op(op_t'(cmd_op))) begin
                        apply     = 1'b1;
                        done_next = 1'b1;
                    end else if (cmd_count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        apply    = 1'b1;
                        rem_next = cmd_count - 1'b1;
                        if (cmd_count == CW'(1))
                            done_next = 1'b1;
                        else
                            state_next = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                apply    = 1'b1;
                rem_next = rem_reg - 1'b1;
                if (rem_reg == CW'(1)) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (apply) begin
            q_next = step_q;
            if (upd_l)
                sout_l_next = lane_l;
            if (upd_r)
                sout_r_next = lane_r;
        end
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign q         = q_reg;
    assign sout_l    = sout_l_reg;
    assign sout_r    = sout_r_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_usr_burst.sv
// Scoreboard bench for usr_burst: two instances (W=1 and W=2 lanes), directed
// commands push hand-computed results; monitors pop and compare on each done pulse.
module tb_usr_burst;
    import usr_pkg::*;

    typedef struct {
        logic [7:0] q;
        logic [1:0] sl;
        logic [1:0] sr;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    // instance A: N=8, W=1
    logic       valid_a = 1'b0, ready_a, busy_a, done_a;
    logic [2:0] op_a = 3'd0;
    logic [3:0] count_a = 4'd0;
    logic [7:0] data_a = 8'd0, q_a;
    logic       lin_a = 1'b0, rin_a = 1'b0, sout_l_a, sout_r_a;

    // instance B: N=8, W=2
    logic       valid_b = 1'b0, ready_b, busy_b, done_b;
    logic [2:0] op_b = 3'd0;
    logic [2:0] count_b = 3'd0;
    logic [7:0] data_b = 8'd0, q_b;
    logic [1:0] lin_b = 2'd0, rin_b = 2'd0, sout_l_b, sout_r_b;

    usr_burst #(.N(8), .W(1)) dut_a (
        .clk(clk), .n_reset(n_reset), .cmd_valid(valid_a), .cmd_ready(ready_a),
        .cmd_op(op_a), .cmd_count(count_a), .cmd_data(data_a), .lin(lin_a), .rin(rin_a),
        .q(q_a), .sout_l(sout_l_a), .sout_r(sout_r_a), .busy(busy_a), .done(done_a)
    );

    usr_burst #(.N(8), .W(2)) dut_b (
        .clk(clk), .n_reset(n_reset), .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_op(op_b), .cmd_count(count_b), .cmd_data(data_b), .lin(lin_b), .rin(rin_b),
        .q(q_b), .sout_l(sout_l_b), .sout_r(sout_r_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_reset && done_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_done_unexpected: got done=1 required no pending command");
            end else begin
                ea = qa.pop_front();
                $display("a: done cyc=%0d q=%h sout_l=%0h sout_r=%0h", cyc, q_a, sout_l_a, sout_r_a);
                chk("a_q", 32'(q_a), 32'(ea.q));
                chk("a_sout_l", 32'(sout_l_a), 32'(ea.sl));
                chk("a_sout_r", 32'(sout_r_a), 32'(ea.sr));
                chk("a_done_cycle", cyc, ea.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (n_reset && done_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_done_unexpected: got done=1 required no pending command");
            end else begin
                eb = qb.pop_front();
                $display("b: done cyc=%0d q=%h sout_l=%0h sout_r=%0h", cyc, q_b, sout_l_b, sout_r_b);
                chk("b_q", 32'(q_b), 32'(eb.q));
                chk("b_sout_l", 32'(sout_l_b), 32'(eb.sl));
                chk("b_sout_r", 32'(sout_r_b), 32'(eb.sr));
                chk("b_done_cycle", cyc, eb.cyc);
            end
        end
    end

    task automatic set_lanes(input int sel, input int i, input logic [31:0] lins, input logic [31:0] rins);
        if (sel == 0) begin
            lin_a = lins[i];
            rin_a = rins[i];
        end else begin
            lin_b = lins[2*i +: 2];
            rin_b = rins[2*i +: 2];
        end
    endtask

    // Issue one command; lane i of lins/rins is presented for step i.
    task automatic issue(input int sel, input logic [2:0] op, input int cnt, input logic [7:0] data,
                         input logic [31:0] lins, input logic [31:0] rins,
                         input logic [7:0] eq, input logic [1:0] esl, input logic [1:0] esr);
        int   budget;
        int   n;
        exp_t e;
        @(negedge clk);
        if (sel == 0) begin
            valid_a = 1'b1; op_a = op; count_a = cnt[3:0]; data_a = data;
        end else begin
            valid_b = 1'b1; op_b = op; count_b = cnt[2:0]; data_b = data;
        end
        set_lanes(sel, 0, lins, rins);
        budget = 0;
        while (!((sel == 0) ? ready_a : ready_b) && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!((sel == 0) ? ready_a : ready_b)) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 required ready=1 within 50 cycles");
            valid_a = 1'b0;
            valid_b = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        n = (cnt > 1) ? cnt : 1;
        e = '{eq, esl, esr, cyc + n - 1};
        if (sel == 0) begin
            qa.push_back(e);
            valid_a = 1'b0;
        end else begin
            qb.push_back(e);
            valid_b = 1'b0;
        end
        if (n > 1)
            chk("busy_after_accept", 32'((sel == 0) ? busy_a : busy_b), 32'd1);
        for (int i = 1; i < n; i++) begin
            set_lanes(sel, i, lins, rins);
            @(posedge clk);
            #1;
        end
        if (n > 1)
            chk("busy_after_last_step", 32'((sel == 0) ? busy_a : busy_b), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int budget;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_q_a", 32'(q_a), 32'h0);
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_q_b", 32'(q_b), 32'h0);
        chk("rst_souts_b", 32'({sout_l_b, sout_r_b}), 32'h0);
        n_reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready_b", 32'(ready_b), 32'd1);

        // asynchronous reset in the middle of a 5-step shift
        issue(0, OP_LOAD, 0, 8'hA5, 0, 0, 8'hA5, 2'd0, 2'd0);
        @(negedge clk);
        valid_a = 1'b1; op_a = OP_SHL; count_a = 4'd5; lin_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        chk("midop_rst_q", 32'(q_a), 32'h0);
        chk("midop_rst_busy", 32'(busy_a), 32'd0);
        chk("midop_rst_ready", 32'(ready_a), 32'd1);
        chk("midop_rst_sout_l", 32'(sout_l_a), 32'd0);
        chk("midop_rst_done", 32'(done_a), 32'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (8) @(negedge clk);

        // W=1 directed vectors
        issue(0, OP_LOAD, 0, 8'hA5, 0, 0, 8'hA5, 2'd0, 2'd0);
        issue(0, OP_SHL, 3, 8'h00, 32'b101, 0, 8'h2D, 2'd1, 2'd0);
        issue(0, OP_LOAD, 0, 8'h96, 0, 0, 8'h96, 2'd1, 2'd0);
        issue(0, OP_ASR, 2, 8'h00, 0, 0, 8'hE5, 2'd1, 2'd1);
        issue(0, OP_LOAD, 0, 8'h81, 0, 0, 8'h81, 2'd1, 2'd1);
        issue(0, OP_ROR, 9, 8'h00, 0, 0, 8'hC0, 2'd1, 2'd1);
        issue(0, OP_CLR, 0, 8'h00, 0, 0, 8'h00, 2'd1, 2'd1);
        issue(0, OP_LOAD, 0, 8'h3C, 0, 0, 8'h3C, 2'd1, 2'd1);
        issue(0, OP_SHR, 2, 8'h00, 0, 32'b01, 8'h4F, 2'd1, 2'd0);
        issue(0, OP_ROL, 3, 8'h00, 0, 0, 8'h7A, 2'd0, 2'd0);
        issue(0, OP_HOLD, 0, 8'hFF, 0, 0, 8'h7A, 2'd0, 2'd0);
        issue(0, OP_SHL, 0, 8'h00, 32'hFFFF_FFFF, 0, 8'h7A, 2'd0, 2'd0);
        issue(0, OP_SHL, 12, 8'h00, 32'hFFFF_FFFF, 0, 8'hFF, 2'd1, 2'd0);
        issue(0, OP_LOAD, 0, 8'h80, 0, 0, 8'h80, 2'd1, 2'd0);
        issue(0, OP_ASR, 10, 8'h00, 0, 0, 8'hFF, 2'd1, 2'd1);
        issue(0, OP_SHR, 1, 8'h00, 0, 0, 8'h7F, 2'd1, 2'd1);

        // command held valid while busy: accepted only on the done cycle
        @(negedge clk);
        valid_a = 1'b1; op_a = OP_SHL; count_a = 4'd3; lin_a = 1'b0;
        budget = 0;
        while (!ready_a && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #1;
        a = cyc;
        qa.push_back('{8'hF8, 2'd1, 2'd1, a + 2});
        op_a = OP_LOAD;
        data_a = 8'h5A;
        @(posedge clk);
        #1;
        chk("held_busy", 32'(busy_a), 32'd1);
        @(posedge clk);
        #1;
        qa.push_back('{8'h5A, 2'd1, 2'd1, cyc + 1});
        @(posedge clk);
        #1;
        valid_a = 1'b0;

        // W=2 directed vectors
        issue(1, OP_LOAD, 0, 8'h1B, 0, 0, 8'h1B, 2'd0, 2'd0);
        issue(1, OP_ROL, 4, 8'h00, 0, 0, 8'h1B, 2'b11, 2'b00);
        issue(1, OP_SHR, 1, 8'h00, 0, 32'b11, 8'hC6, 2'b11, 2'b11);
        issue(1, OP_ASR, 2, 8'h00, 0, 0, 8'hFC, 2'b11, 2'b01);
        issue(1, OP_SHL, 2, 8'h00, 32'b10_01, 0, 8'hC6, 2'b11, 2'b01);
        issue(1, OP_ROR, 5, 8'h00, 0, 0, 8'hB1, 2'b11, 2'b10);
        issue(1, OP_CLR, 0, 8'h00, 0, 0, 8'h00, 2'b11, 2'b10);

        repeat (5) @(negedge clk);
        chk("a_pending_empty", qa.size(), 0);
        chk("b_pending_empty", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
